countdown_sched: RTL and testbench

- Upstream command sequencer for the 8-bit down counter.
- Accepts interval requests (preload value plus optional halve flag) over a valid/ready handshake and buffers them in a small FIFO.
- Drives the counter's load, preload_count and divide_by_2 inputs, watches its zero flag, and reports each completed interval.
- Intervals run back-to-back without host intervention; abort flushes the queue and parks the counter at zero.

---
 rtl/countdown_pkg.sv | 34 +++
 rtl/countdown_sched_if.sv | 35 +++
 rtl/cmd_fifo.sv | 67 ++++++
 rtl/countdown_sched.sv | 167 ++++++++++++++++
 tb/tb_countdown_sched.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/countdown_pkg.sv
// ----------------------------------------------------------------------------
// countdown_pkg
//   Shared types and defaults for the countdown interval scheduler.
//   - sched_state_e : scheduler FSM state encoding
//   - cmd_t         : one queued interval request {halve, count}
//   - make_cmd      : packs the handshake fields into a cmd_t
// ----------------------------------------------------------------------------
package countdown_pkg;

    localparam int CW_DEFAULT    = 8;
    localparam int DEPTH_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        HALVE = 3'd2,
        RUN   = 3'd3,
        PARK  = 3'd4
    } sched_state_e;

    // The queued count width is fixed by the counter this block drives.
    typedef struct packed {
        logic                  halve;
        logic [CW_DEFAULT-1:0] count;
    } cmd_t;

    function automatic cmd_t make_cmd(input logic halve, input logic [CW_DEFAULT-1:0] count);
        cmd_t c;
        c.halve = halve;
        c.count = count;
        return c;
    endfunction

endpackage

// File: rtl/countdown_sched_if.sv
// ----------------------------------------------------------------------------
// countdown_sched_if
//   Command handshake between a host and the countdown scheduler.
//   cmd_valid : host offers a command
//   cmd_ready : scheduler accepts when valid & ready
//   cmd_count : preload value for the interval
//   cmd_halve : apply one divide_by_2 right after the load
//   master = host side, slave = scheduler side.
// ----------------------------------------------------------------------------
interface countdown_sched_if
    import countdown_pkg::*;
#(
    parameter int CW = CW_DEFAULT
);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_count;
    logic          cmd_halve;

    modport master (
        output cmd_valid,
        output cmd_count,
        output cmd_halve,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_count,
        input  cmd_halve,
        output cmd_ready
    );

endinterface

// File: rtl/cmd_fifo.sv
// ----------------------------------------------------------------------------
// cmd_fifo
//   Synchronous show-ahead FIFO of cmd_t entries.
//   clk, rst  : clock, synchronous active-high reset
//   i_push    : write i_wdata (ignored when full)
//   i_pop     : advance read pointer (ignored when empty)
//   i_flush   : empty the FIFO; wins over push and pop
//   o_rdata   : head entry, valid while !o_empty
//   o_full    : no free entry
//   o_empty   : no stored entry
// ----------------------------------------------------------------------------
module cmd_fifo
    import countdown_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  cmd_t i_wdata,
    input  logic i_pop,
    input  logic i_flush,
    output cmd_t o_rdata,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    cmd_t        r_mem [DEPTH];

    logic w_push_ok;
    logic w_pop_ok;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) &&
                       (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset; a write during flush is harmless because the
    // pointers are cleared in the same cycle.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/countdown_sched.sv
// ----------------------------------------------------------------------------
// countdown_sched
//   Command sequencer for an external 8-bit down counter. Queues interval
//   requests, loads the counter, optionally halves it once, waits for zero
//   and reports each completed interval. Intervals run back-to-back.
//
//   clk, rst        : clock, synchronous active-high reset
//   cmd_if (slave)  : cmd_valid/cmd_ready/cmd_count/cmd_halve handshake
//   i_abort         : flush queue, park counter at zero
//   i_ctr_zero      : counter zero flag
//   o_ctr_load      : counter load strobe
//   o_ctr_preload   : counter preload value (0 outside LOAD)
//   o_ctr_div2      : counter divide_by_2 strobe
//   o_done          : one-cycle pulse per completed interval
//   o_done_cnt      : completed-interval count, wraps
//   o_busy          : FSM not idle or queue non-empty
//
//   state | meaning
//   IDLE  | waiting for a queued command
//   LOAD  | load counter with cur.count
//   HALVE | one divide_by_2 on the freshly loaded value
//   RUN   | counting down, waiting for zero
//   PARK  | load counter with 0 after abort
// ----------------------------------------------------------------------------
module countdown_sched
    import countdown_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CW    = CW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    countdown_sched_if.slave    cmd_if,
    input  logic                i_abort,
    input  logic                i_ctr_zero,
    output logic                o_ctr_load,
    output logic [CW-1:0]       o_ctr_preload,
    output logic                o_ctr_div2,
    output logic                o_done,
    output logic [7:0]          o_done_cnt,
    output logic                o_busy
);

    sched_state_e r_state;
    sched_state_e w_next;
    cmd_t         r_cur;
    logic         r_done;
    logic [7:0]   r_done_cnt;

    cmd_t w_wdata;
    cmd_t w_rdata;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_flush;
    logic w_done_set;

    // No bypass: a full queue refuses a push even while it is being popped.
    assign cmd_if.cmd_ready = !w_full && !i_abort;
    assign w_push           = cmd_if.cmd_valid && cmd_if.cmd_ready;
    assign w_wdata          = make_cmd(cmd_if.cmd_halve, cmd_if.cmd_count);

    cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State register, current command and completion bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cur      <= '0;
            r_done     <= 1'b0;
            r_done_cnt <= 8'd0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done_set;
            if (w_pop) begin
                r_cur <= w_rdata;
            end
            if (w_done_set) begin
                r_done_cnt <= r_done_cnt + 8'd1;
            end
        end
    end

    // Next-state logic. A zero seen in RUN completes the interval even if
    // abort arrives in the same cycle, so that done is never lost.
    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_flush    = 1'b0;
        w_done_set = (r_state == RUN) && i_ctr_zero;
        if (i_abort) begin
            w_flush = 1'b1;
            w_next  = PARK;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_next = LOAD;
                    end
                end
                LOAD: begin
                    w_next = r_cur.halve ? HALVE : RUN;
                end
                HALVE: begin
                    w_next = RUN;
                end
                RUN: begin
                    if (i_ctr_zero) begin
                        if (!w_empty) begin
                            w_pop  = 1'b1;
                            w_next = LOAD;
                        end else begin
                            w_next = IDLE;
                        end
                    end
                end
                PARK: begin
                    w_next = IDLE;
                end
                default: begin
                    w_next = IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from state and the current command.
    always_comb begin
        o_ctr_load    = 1'b0;
        o_ctr_preload = '0;
        o_ctr_div2    = 1'b0;
        case (r_state)
            LOAD: begin
                o_ctr_load    = 1'b1;
                o_ctr_preload = r_cur.count;
            end
            HALVE: begin
                o_ctr_div2 = 1'b1;
            end
            PARK: begin
                o_ctr_load = 1'b1;
            end
            default: begin
                o_ctr_load = 1'b0;
            end
        endcase
        o_busy = (r_state != IDLE) || !w_empty;
    end

    assign o_done     = r_done;
    assign o_done_cnt = r_done_cnt;

endmodule

// File: tb/tb_countdown_sched.sv
// ----------------------------------------------------------------------------
// tb_countdown_sched
//   Directed bench for countdown_sched with a behavioural down counter.
// ----------------------------------------------------------------------------
module tb_countdown_sched;
    import countdown_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       abort = 1'b0;
    logic       ctr_zero;
    logic       ctr_load;
    logic       ctr_div2;
    logic       done;
    logic       busy;
    logic [7:0] ctr_preload;
    logic [7:0] done_cnt;
    logic [7:0] cnt;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int done_q[$];
    int load_q[$];
    int pre_q[$];

    countdown_sched_if #(.CW(8)) cmd_if();

    countdown_sched #(
        .DEPTH (4),
        .CW    (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_if        (cmd_if),
        .i_abort       (abort),
        .i_ctr_zero    (ctr_zero),
        .o_ctr_load    (ctr_load),
        .o_ctr_preload (ctr_preload),
        .o_ctr_div2    (ctr_div2),
        .o_done        (done),
        .o_done_cnt    (done_cnt),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 8-bit down counter: load > divide_by_2 > decrement.
    always @(posedge clk) begin
        if (rst)           cnt <= 8'd0;
        else if (ctr_load) cnt <= ctr_preload;
        else if (ctr_div2) cnt <= cnt >> 1;
        else if (cnt != 0) cnt <= cnt - 8'd1;
    end
    assign ctr_zero = (cnt == 8'd0);

    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_q.push_back(cyc);
            if (ctr_load) begin
                load_q.push_back(cyc);
                pre_q.push_back(int'(ctr_preload));
            end
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_q(input string tag, input int got[$], input int exp[$]);
        chk({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic clear_q();
        done_q.delete();
        load_q.delete();
        pre_q.delete();
    endtask

    // Offers one command; acc returns the cycle in which it was accepted.
    task automatic push(input int n, input logic h, output int acc);
        int budget;
        budget = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_count = 8'(n);
        cmd_if.cmd_halve = h;
        while (!cmd_if.cmd_ready && budget < 400) begin
            tick();
            budget++;
        end
        if (!cmd_if.cmd_ready) chk("push_timeout", 1, 0);
        acc = cyc;
        tick();
        cmd_if.cmd_valid = 1'b0;
    endtask

    initial begin
        int c;
        int c1;
        int c2;
        int c3;
        int c4;
        int exp_d[$];
        int exp_l[$];
        int exp_p[$];

        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_count = 8'd0;
        cmd_if.cmd_halve = 1'b0;

        // Reset state
        rst = 1'b1;
        tick(); tick(); tick();
        chk("rst_load",   int'(ctr_load), 0);
        chk("rst_pre",    int'(ctr_preload), 0);
        chk("rst_div2",   int'(ctr_div2), 0);
        chk("rst_done",   int'(done), 0);
        chk("rst_dcnt",   int'(done_cnt), 0);
        chk("rst_busy",   int'(busy), 0);
        chk("rst_ready",  int'(cmd_if.cmd_ready), 1);
        rst = 1'b0;
        tick(); tick();

        // Single interval {3,0}
        clear_q();
        push(3, 1'b0, c);
        wait_until(c + 2);
        chk("t1_load", int'(ctr_load), 1);
        chk("t1_pre",  int'(ctr_preload), 3);
        wait_until(c + 8);
        chk("t1_busy", int'(busy), 0);
        chk("t1_dcnt", int'(done_cnt), 1);
        exp_d = {c + 7};
        chk_q("t1_done", done_q, exp_d);

        // Halve {6,1}
        clear_q();
        push(6, 1'b1, c);
        wait_until(c + 2);
        chk("t2_load", int'(ctr_load), 1);
        chk("t2_pre",  int'(ctr_preload), 6);
        wait_until(c + 3);
        chk("t2_div2", int'(ctr_div2), 1);
        chk("t2_load_off", int'(ctr_load), 0);
        wait_until(c + 10);
        exp_d = {c + 8};
        chk_q("t2_done", done_q, exp_d);
        chk("t2_dcnt", int'(done_cnt), 2);

        // Back-to-back {2,0},{0,0},{5,1}
        clear_q();
        push(2, 1'b0, c);
        push(0, 1'b0, c1);
        push(5, 1'b1, c2);
        chk("t3_acc1", c1, c + 1);
        chk("t3_acc2", c2, c + 2);
        wait_until(c + 16);
        exp_l = {c + 2, c + 6, c + 8};
        exp_p = {2, 0, 5};
        exp_d = {c + 6, c + 8, c + 13};
        chk_q("t3_load", load_q, exp_l);
        chk_q("t3_pre",  pre_q, exp_p);
        chk_q("t3_done", done_q, exp_d);
        chk("t3_dcnt", int'(done_cnt), 5);
        chk("t3_busy", int'(busy), 0);

        // Backpressure behind a long interval
        clear_q();
        push(200, 1'b0, c);
        push(1, 1'b0, c1);
        push(2, 1'b0, c2);
        push(3, 1'b1, c3);
        push(4, 1'b0, c4);
        chk("t4_acc4", c4, c + 4);
        chk("t4_ready_full", int'(cmd_if.cmd_ready), 0);
        push(5, 1'b0, c1);
        chk("t4_acc5", c1, c + 204);
        wait_until(c + 232);
        exp_l = {c + 2, c + 204, c + 207, c + 211, c + 215, c + 221};
        exp_p = {200, 1, 2, 3, 4, 5};
        exp_d = {c + 204, c + 207, c + 211, c + 215, c + 221, c + 228};
        chk_q("t4_load", load_q, exp_l);
        chk_q("t4_pre",  pre_q, exp_p);
        chk_q("t4_done", done_q, exp_d);
        chk("t4_dcnt", int'(done_cnt), 11);

        // Abort in RUN with two entries queued
        clear_q();
        push(50, 1'b0, c);
        push(7, 1'b0, c1);
        push(8, 1'b0, c2);
        wait_until(c + 10);
        abort = 1'b1;
        #1;
        chk("t5_ready_abort", int'(cmd_if.cmd_ready), 0);
        tick();
        abort = 1'b0;
        chk("t5_park_load", int'(ctr_load), 1);
        chk("t5_park_pre",  int'(ctr_preload), 0);
        tick();
        chk("t5_idle_busy", int'(busy), 0);
        chk("t5_idle_load", int'(ctr_load), 0);
        wait_until(c + 80);
        chk("t5_no_done", done_q.size(), 0);
        chk("t5_dcnt",    int'(done_cnt), 11);
        chk("t5_busy",    int'(busy), 0);

        // Reset mid-run, then a normal interval
        clear_q();
        push(100, 1'b0, c);
        wait_until(c + 20);
        rst = 1'b1;
        tick();
        chk("t6_load", int'(ctr_load), 0);
        chk("t6_pre",  int'(ctr_preload), 0);
        chk("t6_div2", int'(ctr_div2), 0);
        chk("t6_done", int'(done), 0);
        chk("t6_dcnt", int'(done_cnt), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_ready", int'(cmd_if.cmd_ready), 1);
        rst = 1'b0;
        wait_until(c + 150);
        chk("t6_no_done", done_q.size(), 0);
        clear_q();
        push(4, 1'b0, c);
        wait_until(c + 10);
        exp_d = {c + 8};
        chk_q("t6_new_done", done_q, exp_d);
        chk("t6_new_dcnt", int'(done_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
